// File: rtl/game_tick_gen.sv
// ---------------------------------------------------------------------------
// game_tick_gen
//
// Speed-ramping tick generator for the snake game core. Produces a one-cycle
// seconds strobe, a one-cycle game-step strobe whose period shrinks as the
// difficulty level rises, and the difficulty level itself. Everything can be
// paused with enable and cleared with a synchronous restart.
//
// Parameters:
//   CNT_W          width of all period counters
//   SEC_PERIOD     clocks per seconds tick
//   BASE_PERIOD    game-step period at level 0
//   STEP           period reduction per level
//   MIN_PERIOD     lower clamp on the game-step period (1..BASE_PERIOD)
//   LEVEL_W        level counter width
//   SECS_PER_LEVEL seconds per level increment (>= 1)
//
// Ports:
//   clk        in   system clock
//   reset_n    in   asynchronous active-low reset
//   enable     in   1 = run, 0 = pause (counters hold, no ticks)
//   restart    in   synchronous clear of all state, wins over enable
//   sec_tick   out  one-cycle pulse every SEC_PERIOD enabled cycles
//   game_tick  out  one-cycle pulse every current game period
//   level      out  current difficulty level (saturating)
//   level_max  out  high while level is at its top value
//   period     out  current game-step period, registered
// ---------------------------------------------------------------------------
module game_tick_gen #(
  parameter int CNT_W          = 32,
  parameter int SEC_PERIOD     = 50_000_000,
  parameter int BASE_PERIOD    = 12_500_000,
  parameter int STEP           = 2048,
  parameter int MIN_PERIOD     = 1_000_000,
  parameter int LEVEL_W        = 8,
  parameter int SECS_PER_LEVEL = 10
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               restart,
  output logic               sec_tick,
  output logic               game_tick,
  output logic [LEVEL_W-1:0] level,
  output logic               level_max,
  output logic [CNT_W-1:0]   period
);

  // The period arithmetic is carried out wide enough that level*STEP can
  // never overflow, so the subtraction's underflow can be detected exactly.
  localparam int WIDE_W = CNT_W + LEVEL_W;
  localparam int LSC_W  = (SECS_PER_LEVEL > 1) ? $clog2(SECS_PER_LEVEL) : 1;

  localparam logic [CNT_W-1:0]   SEC_LAST  = CNT_W'(SEC_PERIOD - 1);
  localparam logic [LSC_W-1:0]   LSC_LAST  = LSC_W'(SECS_PER_LEVEL - 1);
  localparam logic [LEVEL_W-1:0] LEVEL_TOP = '1;
  localparam logic [CNT_W-1:0]   BASE_C    = CNT_W'(BASE_PERIOD);
  localparam logic [CNT_W-1:0]   MIN_C     = CNT_W'(MIN_PERIOD);
  localparam logic [WIDE_W-1:0]  BASE_W    = WIDE_W'(BASE_PERIOD);
  localparam logic [WIDE_W-1:0]  STEP_W    = WIDE_W'(STEP);
  localparam logic [WIDE_W-1:0]  MIN_W     = WIDE_W'(MIN_PERIOD);

  logic [CNT_W-1:0]   sec_cnt_q, sec_cnt_d;
  logic [LSC_W-1:0]   lvl_sec_cnt_q, lvl_sec_cnt_d;
  logic [CNT_W-1:0]   game_cnt_q, game_cnt_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic               level_max_q, level_max_d;
  logic [CNT_W-1:0]   period_q, period_d;
  logic               sec_tick_q, sec_tick_d;
  logic               game_tick_q, game_tick_d;

  logic [WIDE_W-1:0]  step_total;
  logic [WIDE_W-1:0]  period_diff;
  logic               period_under;
  logic [CNT_W-1:0]   period_target;

  logic               sec_wrap;
  logic               lvl_wrap;
  logic               game_wrap;

  // Target game period for the currently registered level:
  // max(BASE - level*STEP, MIN). A difference that would go negative is
  // caught by the explicit underflow flag rather than allowed to wrap.
  always_comb begin
    step_total    = WIDE_W'(level_q) * STEP_W;
    period_under  = (step_total > BASE_W);
    period_diff   = BASE_W - step_total;
    period_target = period_diff[CNT_W-1:0];
    if (period_under || (period_diff < MIN_W)) begin
      period_target = MIN_C;
    end
  end

  // Wrap conditions for the three counters. The game counter uses >= so a
  // period that drops below the running count fires on the next enabled
  // cycle instead of waiting for a full wrap of the counter.
  always_comb begin
    sec_wrap  = (sec_cnt_q == SEC_LAST);
    lvl_wrap  = (lvl_sec_cnt_q == LSC_LAST);
    game_wrap = (game_cnt_q >= (period_q - CNT_W'(1)));
  end

  // Next-state logic for all counters and registered outputs. Restart takes
  // priority and mirrors the reset state; a paused cycle holds every count
  // and forces both strobes low. The period register follows the level on
  // every clock regardless of enable, which costs nothing since the level
  // cannot change while paused.
  always_comb begin
    sec_cnt_d     = sec_cnt_q;
    lvl_sec_cnt_d = lvl_sec_cnt_q;
    game_cnt_d    = game_cnt_q;
    level_d       = level_q;
    period_d      = period_target;
    sec_tick_d    = 1'b0;
    game_tick_d   = 1'b0;

    if (restart) begin
      sec_cnt_d     = '0;
      lvl_sec_cnt_d = '0;
      game_cnt_d    = '0;
      level_d       = '0;
      period_d      = BASE_C;
    end else if (enable) begin
      if (sec_wrap) begin
        sec_cnt_d  = '0;
        sec_tick_d = 1'b1;
        // Level only advances on a seconds wrap; the per-level second count
        // keeps cycling even once the level has saturated.
        if (lvl_wrap) begin
          lvl_sec_cnt_d = '0;
          if (level_q != LEVEL_TOP) begin
            level_d = level_q + LEVEL_W'(1);
          end
        end else begin
          lvl_sec_cnt_d = lvl_sec_cnt_q + LSC_W'(1);
        end
      end else begin
        sec_cnt_d = sec_cnt_q + CNT_W'(1);
      end

      if (game_wrap) begin
        game_cnt_d  = '0;
        game_tick_d = 1'b1;
      end else begin
        game_cnt_d = game_cnt_q + CNT_W'(1);
      end
    end

    level_max_d = (level_d == LEVEL_TOP);
  end

  // State register. Reset clears the counters immediately, without a clock,
  // and loads the level-0 period.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sec_cnt_q     <= '0;
      lvl_sec_cnt_q <= '0;
      game_cnt_q    <= '0;
      level_q       <= '0;
      level_max_q   <= 1'b0;
      period_q      <= BASE_C;
      sec_tick_q    <= 1'b0;
      game_tick_q   <= 1'b0;
    end else begin
      sec_cnt_q     <= sec_cnt_d;
      lvl_sec_cnt_q <= lvl_sec_cnt_d;
      game_cnt_q    <= game_cnt_d;
      level_q       <= level_d;
      level_max_q   <= level_max_d;
      period_q      <= period_d;
      sec_tick_q    <= sec_tick_d;
      game_tick_q   <= game_tick_d;
    end
  end

  // All outputs come straight from flops.
  assign sec_tick  = sec_tick_q;
  assign game_tick = game_tick_q;
  assign level     = level_q;
  assign level_max = level_max_q;
  assign period    = period_q;

endmodule
